rr_grant_sched8: RTL and testbench
==================================

Name: rr_grant_sched8

Overview:
- Eight-requester round-robin scheduler that shares one decoded resource between requesters.
- Example resource: an LED bank or peripheral select line.
- Picks a requester, holds the grant while it keeps requesting (up to a hold limit), then passes priority to the next index.
- Outputs a 3-bit index `sel` and its one-hot decode `gnt`. `gnt` follows the same index-to-bit mapping as the team's 3-to-8 decoder: index k asserts bit k.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles a grant may be held. 0 means unlimited.
- HOLD_W, 8: width of the hold counter. Must satisfy MAX_HOLD < 2^HOLD_W.

Ports:
- clk  input  1  system clock. All logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  allows new grants to be issued. Does not pre-empt an active grant.
- req  input  8  request vector. Bit k is requester k. Level-sensitive.
- sel  output  3  index of the current or last granted requester. Registered.
- gnt  output  8  one-hot grant. Equals 1<<sel when gnt_valid=1, otherwise 0.
- gnt_valid  output  1  grant active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- **Reset** (rst=1 at a clock edge): the following all go to 0.
  - state = IDLE, priority pointer ptr, sel, gnt, gnt_valid, timeout, hold counter cnt.
  - rst overrides every other input, including mid-grant: gnt drops on the cycle after rst is sampled high.
- **State IDLE**
  - If en=1 and req≠0, choose the first set bit of req scanning ptr, ptr+1, … ptr+7 (mod 8).
  - Register that index into sel, set gnt_valid=1 and cnt=0, and go to GRANT.
  - Latency: the grant is visible one cycle after the edge at which the request is sampled.
  - If en=0 or req=0: stay in IDLE. gnt_valid=0; sel keeps its last value.
- **State GRANT**
  - gnt_valid=1 and gnt=1<<sel. cnt increments each cycle, saturating at 2^HOLD_W−1.
  - If req[sel]=0: go to RELEASE.
  - Else if MAX_HOLD≠0 and cnt=MAX_HOLD−1: go to RELEASE and assert timeout for exactly one cycle, coincident with the first RELEASE cycle.
  - Otherwise: stay in GRANT.
  - Total grant length is at most MAX_HOLD cycles.
  - Other req bits and en are ignored while in GRANT.
- **State RELEASE**
  - Exactly one cycle, with gnt_valid=0 and gnt=0 (a dead cycle guarantees a break before any new grant).
  - Set ptr = (sel+1) mod 8 and go to IDLE.
- **Arithmetic**
  - ptr and index addition are 3-bit and wrap 7→0.
  - Priority search is combinational over the 8 rotated positions.
- **Fairness**
  - With all 8 requesters continuously asserting, grants cycle 0,1,…,7,0.
  - Grant-to-grant spacing with continuous requests is hold + 2 cycles (RELEASE + IDLE).
- **Boundaries**
  - Requester drops req on the same cycle it is granted: GRANT lasts one cycle, then RELEASE.
  - Single requester repeatedly requesting: it is re-granted after each RELEASE/IDLE gap, even when it is the only requester.
  - req changes during RELEASE have no effect. IDLE samples req on its own cycle.
  - en falling during GRANT does not shorten the grant.
- **Invariant**: gnt is always zero or exactly one-hot, and gnt≠0 if and only if gnt_valid=1.

Test Plan:
1. **Reset**: rst=1 for 2 cycles with req=8'hFF → sel=0, gnt=0, gnt_valid=0, timeout=0 throughout.
2. **Single request**: after reset, req=8'b0000_0100 held 5 cycles then cleared.
   - gnt=8'h04 and sel=2 from 1 cycle after req is first sampled, for 5 cycles.
   - Then one cycle of gnt=0, then IDLE.
3. **Rotation**: req=8'hFF held permanently with MAX_HOLD=4.
   - Grants 0,1,2,…,7,0 in order, each 4 cycles long.
   - timeout pulses once per grant, 2 dead cycles between grants.
4. **Wrap priority**: grant index 6 and release it, then apply req=8'b0100_0001 → next grant is index 0, not 6. Then apply req=8'b0100_0001 again → grant index 6.
5. **Enable gating**: en=0 with req=8'h10 → no grant. Raise en → gnt=8'h10 one cycle later. Drop en mid-grant → grant continues until req[4]=0.
6. **Reset mid-grant**: assert rst on the 3rd cycle of a grant to index 5 → gnt=0 next cycle, then ptr=0, so req=8'h21 yields index 0.

Source files
------------

// File: rtl/rr_grant_sched8.sv
// rtl/rr_grant_sched8.sv - eight-requester round-robin grant scheduler with hold limit
//
// Shares one decoded resource between eight level-sensitive requesters.
// A grant is held while its requester keeps asking, up to MAX_HOLD cycles
// (0 = unlimited). A one-cycle RELEASE gap always follows a grant. After that
// gap, priority moves to the index after the one just served.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         allows new grants from IDLE (does not pre-empt a held grant)
//   req[7:0]   request vector, bit k = requester k
//   sel[2:0]   index of the current or last granted requester (registered)
//   gnt[7:0]   one-hot grant, 1<<sel while gnt_valid, else 0
//   gnt_valid  grant active
//   timeout    one-cycle pulse on the first RELEASE cycle after a hold-limit revoke
module rr_grant_sched8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] CNT_MAX   = '1;
    // Last allowed hold cycle. Unused when MAX_HOLD is 0 because the compare is gated.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    state_t            state;
    state_t            state_next;
    logic [2:0]        ptr;
    logic [2:0]        ptr_next;
    logic [2:0]        sel_next;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_next;
    logic              timeout_next;

    logic [15:0]       req_dbl;
    logic [7:0]        req_rot;
    logic              found;
    logic [2:0]        pick;

    // Rotate req so that bit 0 of req_rot is requester ptr. The lowest set
    // bit of req_rot is then the winner. The loop runs downward, so the
    // smallest offset is the last assignment and takes effect.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: 8];
        found   = 1'b0;
        pick    = ptr;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                found = 1'b1;
                pick  = ptr + 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            sel     <= 3'd0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            sel     <= sel_next;
            cnt     <= cnt_next;
            timeout <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        sel_next     = sel;
        cnt_next     = cnt;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    state_next = GRANT;
                    sel_next   = pick;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    state_next = RELEASE;
                end else if ((MAX_HOLD != 0) && (cnt == HOLD_LAST)) begin
                    // The pulse is registered, so it lines up with the first RELEASE cycle.
                    state_next   = RELEASE;
                    timeout_next = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RELEASE: begin
                ptr_next   = sel + 3'd1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_valid = (state == GRANT);
        gnt       = gnt_valid ? (8'b1 << sel) : 8'h00;
    end

endmodule

// File: tb/tb_rr_grant_sched8.sv
// tb/tb_rr_grant_sched8.sv - self-checking bench for rr_grant_sched8
module tb_rr_grant_sched8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;

    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;
    logic [2:0] sel4;
    logic [7:0] gnt4;
    logic       gnt_valid4;
    logic       timeout4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_grant_sched8 #(.MAX_HOLD(16), .HOLD_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    rr_grant_sched8 #(.MAX_HOLD(4), .HOLD_W(8)) dut4 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .sel(sel4), .gnt(gnt4), .gnt_valid(gnt_valid4), .timeout(timeout4)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic r, input logic e, input logic [7:0] q,
                       input logic [2:0] s, input logic [7:0] g, input logic v, input logic t);
        vec_t x;
        x.name = nm; x.rst = r; x.en = e; x.req = q;
        x.sel = s; x.gnt = g; x.valid = v; x.to = t;
        vecs.push_back(x);
    endtask

    // Packed as {sel[2:0], gnt[7:0], gnt_valid, timeout}.
    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got sel=%0d gnt=%02h valid=%0b timeout=%0b, expected sel=%0d gnt=%02h valid=%0b timeout=%0b",
                     name, $time, act[12:10], act[9:2], act[1], act[0],
                     exp[12:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // Behavioural reference. It tracks who owns the resource, how many cycles
    // that owner has held it, and whether a dead cycle is pending.
    int m_busy[2];
    int m_gap[2];
    int m_to[2];
    int m_owner[2];
    int m_len[2];
    int m_last[2];
    int m_next[2];
    int m_maxh[2] = '{16, 4};

    task automatic model_step(input int i, input logic r, input logic e, input logic [7:0] q);
        m_to[i] = 0;
        if (r) begin
            m_busy[i] = 0; m_gap[i] = 0; m_len[i] = 0;
            m_last[i] = 0; m_next[i] = 0; m_owner[i] = 0;
        end else if (m_gap[i] != 0) begin
            m_gap[i]  = 0;
            m_next[i] = (m_last[i] + 1) % 8;
        end else if (m_busy[i] != 0) begin
            if (!q[m_owner[i]]) begin
                m_busy[i] = 0; m_gap[i] = 1;
            end else if (m_maxh[i] != 0 && m_len[i] == m_maxh[i]) begin
                m_busy[i] = 0; m_gap[i] = 1; m_to[i] = 1;
            end else begin
                m_len[i]++;
            end
        end else if (e && q != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (m_next[i] + k) % 8;
                if (q[idx]) begin
                    m_owner[i] = idx; m_last[i] = idx; m_busy[i] = 1; m_len[i] = 1;
                    break;
                end
            end
        end
    endtask

    function automatic logic [12:0] model_out(input int i);
        logic [7:0] g;
        g = (m_busy[i] != 0) ? (8'(1) << m_last[i]) : 8'h00;
        return {3'(m_last[i]), g, m_busy[i] != 0, m_to[i] != 0};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] oh;
        logic       gnt_ok;

        rst = 1'b1; en = 1'b0; req = 8'h00;

        // Vectors for the MAX_HOLD=16 instance. Each row lists the inputs
        // applied before an edge and the outputs expected just after it.
        add("reset0",      1, 1, 8'hFF, 0, 8'h00, 0, 0);
        add("reset1",      1, 1, 8'hFF, 0, 8'h00, 0, 0);
        add("single_g1",   0, 1, 8'h04, 2, 8'h04, 1, 0);
        add("single_g2",   0, 1, 8'h04, 2, 8'h04, 1, 0);
        add("single_g3",   0, 1, 8'h04, 2, 8'h04, 1, 0);
        add("single_g4",   0, 1, 8'h04, 2, 8'h04, 1, 0);
        add("single_g5",   0, 1, 8'h04, 2, 8'h04, 1, 0);
        add("single_rel",  0, 1, 8'h00, 2, 8'h00, 0, 0);
        add("single_idle", 0, 1, 8'h00, 2, 8'h00, 0, 0);
        add("en_off0",     0, 0, 8'h10, 2, 8'h00, 0, 0);
        add("en_off1",     0, 0, 8'h10, 2, 8'h00, 0, 0);
        add("en_on",       0, 1, 8'h10, 4, 8'h10, 1, 0);
        add("en_drop0",    0, 0, 8'h10, 4, 8'h10, 1, 0);
        add("en_drop1",    0, 0, 8'h10, 4, 8'h10, 1, 0);
        add("en_rel",      0, 0, 8'h00, 4, 8'h00, 0, 0);
        add("en_idle",     0, 0, 8'h00, 4, 8'h00, 0, 0);
        add("wrap_g6",     0, 1, 8'h40, 6, 8'h40, 1, 0);
        add("wrap_rel6",   0, 1, 8'h00, 6, 8'h00, 0, 0);
        add("wrap_relreq", 0, 1, 8'h41, 6, 8'h00, 0, 0);
        add("wrap_g0",     0, 1, 8'h41, 0, 8'h01, 1, 0);
        add("wrap_rel0",   0, 1, 8'h00, 0, 8'h00, 0, 0);
        add("wrap_idle0",  0, 1, 8'h00, 0, 8'h00, 0, 0);
        add("wrap_g6b",    0, 1, 8'h41, 6, 8'h40, 1, 0);
        add("wrap_rel6b",  0, 1, 8'h00, 6, 8'h00, 0, 0);
        add("wrap_idle6b", 0, 1, 8'h00, 6, 8'h00, 0, 0);
        add("rstmid_g1",   0, 1, 8'h20, 5, 8'h20, 1, 0);
        add("rstmid_g2",   0, 1, 8'h20, 5, 8'h20, 1, 0);
        add("rstmid_g3",   0, 1, 8'h20, 5, 8'h20, 1, 0);
        add("rstmid_rst",  1, 1, 8'h20, 0, 8'h00, 0, 0);
        add("rstmid_g0",   0, 1, 8'h21, 0, 8'h01, 1, 0);
        add("rstmid_rel",  0, 1, 8'h00, 0, 8'h00, 0, 0);
        add("rstmid_idle", 0, 1, 8'h00, 0, 8'h00, 0, 0);
        add("drop_g3",     0, 1, 8'h08, 3, 8'h08, 1, 0);
        add("drop_rel",    0, 1, 8'h00, 3, 8'h00, 0, 0);
        add("drop_idle",   0, 1, 8'h00, 3, 8'h00, 0, 0);
        add("solo_g3",     0, 1, 8'h08, 3, 8'h08, 1, 0);
        add("solo_rel",    0, 1, 8'h00, 3, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; req = vecs[i].req;
            @(posedge clk);
            #1;
            check(vecs[i].name, {sel, gnt, gnt_valid, timeout},
                  {vecs[i].sel, vecs[i].gnt, vecs[i].valid, vecs[i].to});
        end

        // Hold-limit timeout with MAX_HOLD=16: seventeen edges with req[1] held.
        rst = 1'b1; en = 1'b1; req = 8'h02;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            check("hold16_grant", {sel, gnt, gnt_valid, timeout}, {3'd1, 8'h02, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        check("hold16_timeout", {sel, gnt, gnt_valid, timeout}, {3'd1, 8'h00, 1'b0, 1'b1});
        @(posedge clk); #1;
        check("hold16_idle", {sel, gnt, gnt_valid, timeout}, {3'd1, 8'h00, 1'b0, 1'b0});
        @(posedge clk); #1;
        check("hold16_regrant", {sel, gnt, gnt_valid, timeout}, {3'd1, 8'h02, 1'b1, 1'b0});

        // Full rotation on the MAX_HOLD=4 instance with every requester asserting.
        rst = 1'b1; en = 1'b1; req = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int g = 0; g < 9; g++) begin
            oh = 8'(1) << (g % 8);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                check("rot_grant", {sel4, gnt4, gnt_valid4, timeout4}, {3'(g % 8), oh, 1'b1, 1'b0});
            end
            @(posedge clk); #1;
            check("rot_release", {sel4, gnt4, gnt_valid4, timeout4}, {3'(g % 8), 8'h00, 1'b0, 1'b1});
            @(posedge clk); #1;
            check("rot_idle", {sel4, gnt4, gnt_valid4, timeout4}, {3'(g % 8), 8'h00, 1'b0, 1'b0});
        end

        // Randomised run of both instances against the reference model.
        rst = 1'b1; en = 1'b1; req = 8'h00;
        @(posedge clk);
        model_step(0, rst, en, req);
        model_step(1, rst, en, req);
        #1;
        check("rand_reset16", {sel, gnt, gnt_valid, timeout}, model_out(0));
        check("rand_reset4", {sel4, gnt4, gnt_valid4, timeout4}, model_out(1));
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 8'h00;
                    1: req = 8'(1) << $urandom_range(0, 7);
                    2: req = 8'($urandom);
                    default: req = 8'hFF;
                endcase
            end
            @(posedge clk);
            model_step(0, rst, en, req);
            model_step(1, rst, en, req);
            #1;
            check("rand16", {sel, gnt, gnt_valid, timeout}, model_out(0));
            check("rand4", {sel4, gnt4, gnt_valid4, timeout4}, model_out(1));
            gnt_ok = ($countones(gnt4) <= 1) && ((gnt4 != 8'h00) == gnt_valid4);
            n_cmp++;
            if (!gnt_ok) begin
                n_bad++;
                $display("FAIL invariant4 @%0t: got gnt=%02h valid=%0b, required one-hot-or-zero matching valid",
                         $time, gnt4, gnt_valid4);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
